// File: rtl/uart_rx.sv
// Oversampling UART receiver: 2-flop synchroniser, start/data/stop deframer,
// and a small FIFO toward the consumer with rts flow control.
module uart_rx #(
    parameter int DATA_BITS  = 7,
    parameter int OVERSAMPLE = 16,
    parameter int DEPTH      = 4
) (
    input  logic                 rst,
    input  logic                 baud_clk,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 rts,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int PW = $clog2(DEPTH);

    localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic [PW:0]   FULL     = (PW + 1)'(DEPTH);
    localparam logic [PW:0]   RTS_LIM  = (PW + 1)'(DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t                state, state_next;
    logic                  rx_m, rx_s;
    logic [TW-1:0]         tick_cnt, tick_next;
    logic [BW-1:0]         bit_idx, bit_next;
    logic [DATA_BITS-1:0]  shift, shift_next;
    logic                  push_q, push_next;
    logic                  ferr_next;

    logic [DATA_BITS-1:0]  mem [DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [PW:0]           count;
    logic                  pop, accept;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge baud_clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge baud_clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            push_q    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_next;
            tick_cnt  <= tick_next;
            bit_idx   <= bit_next;
            shift     <= shift_next;
            push_q    <= push_next;
            frame_err <= ferr_next;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_next = state;
        tick_next  = tick_cnt + 1'b1;
        bit_next   = bit_idx;
        shift_next = shift;
        push_next  = 1'b0;
        ferr_next  = 1'b0;
        case (state)
            IDLE: begin
                tick_next = '0;
                if (!rx_s) state_next = START;
            end
            START: begin
                if (tick_cnt == TICK_MID) begin
                    tick_next  = '0;
                    bit_next   = '0;
                    state_next = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick_cnt == TICK_END) begin
                    tick_next           = '0;
                    shift_next[bit_idx] = rx_s;
                    bit_next            = bit_idx + 1'b1;
                    if (bit_idx == LAST_BIT) state_next = STOP;
                end
            end
            STOP: begin
                if (tick_cnt == TICK_END) begin
                    tick_next = '0;
                    if (rx_s) begin
                        push_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                tick_next = '0;
                if (rx_s) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // shift is stable for many ticks after STOP, so the delayed push can use it directly.
    assign pop    = data_valid && data_ready;
    assign accept = push_q && ((count < FULL) || pop);

    // NOTE: FIFO storage is reset too, so data_out is defined (zero) out of reset.
    always_ff @(posedge baud_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rts     <= 1'b1;
            overrun <= 1'b0;
        end else begin
            if (accept) begin
                mem[wr_ptr] <= shift;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            rts     <= (count < RTS_LIM);
            overrun <= push_q && !accept;
        end
    end

    assign data_out   = mem[rd_ptr];
    assign data_valid = (count != '0);
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: framed serial stimulus at 16 ticks/bit with
// table-driven frame/pop vectors plus hand sequences for glitch, break and reset.
module tb_uart_rx;

    localparam int OS = 16;

    logic       rst;
    logic       baud_clk;
    logic       rx;
    logic       data_ready;
    logic [6:0] data_out;
    logic       data_valid;
    logic       rts;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int checks = 0;
    int errors = 0;

    uart_rx #(
        .DATA_BITS (7),
        .OVERSAMPLE(OS),
        .DEPTH     (4)
    ) dut (
        .rst       (rst),
        .baud_clk  (baud_clk),
        .rx        (rx),
        .data_out  (data_out),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .rts       (rts),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    initial baud_clk = 1'b0;
    always #5 baud_clk = ~baud_clk;

    typedef struct {
        logic [6:0] data;
        int         pop_at;
        int         exp_valid_at;
        int         exp_ovr;
        logic       exp_rts;
    } frame_vec_t;

    typedef struct {
        logic [6:0] data;
        logic       exp_rts;
    } pop_vec_t;

    frame_vec_t frames [10];
    pop_vec_t   pops   [8];

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge baud_clk);
        #1;
    endtask

    // Drives start, 7 data bits LSB first, stop bit, then 'tail' level, for len ticks.
    // valid_at is the tick index at which data_valid first rises (-1 if it never does).
    task automatic run_frame(input logic [6:0] d, input logic stop_bit, input logic tail,
                             input int len, input int pop_at,
                             output int valid_at, output int ferr_n, output int ovr_n);
        logic [9:0] bits;
        logic       was_valid;
        int         idx;
        bits      = {tail, stop_bit, d, 1'b0};
        valid_at  = -1;
        ferr_n    = 0;
        ovr_n     = 0;
        was_valid = data_valid;
        for (int n = 0; n < len; n++) begin
            idx = n / OS;
            if (idx > 9) idx = 9;
            rx         = bits[idx];
            data_ready = (n == pop_at);
            tick();
            if (data_valid && !was_valid && valid_at < 0) valid_at = n + 1;
            was_valid = data_valid;
            ferr_n += int'(frame_err);
            ovr_n  += int'(overrun);
        end
        data_ready = 1'b0;
    endtask

    task automatic pop_check(input pop_vec_t v, input int i);
        check($sformatf("pop%0d valid", i), data_valid, 1);
        check($sformatf("pop%0d data", i), data_out, v.data);
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
        tick();
        check($sformatf("pop%0d rts", i), rts, v.exp_rts);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, expected run to end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int va, fe, ov, busy_n, flag_n, valid_n;

        // Flow control / overrun frames, then push-pop collision frames.
        frames[0] = '{7'h01, -1, 140, 0, 1'b1};
        frames[1] = '{7'h02, -1,  -1, 0, 1'b1};
        frames[2] = '{7'h03, -1,  -1, 0, 1'b0};
        frames[3] = '{7'h04, -1,  -1, 0, 1'b0};
        frames[4] = '{7'h05, -1,  -1, 1, 1'b0};
        frames[5] = '{7'h11, -1, 140, 0, 1'b1};
        frames[6] = '{7'h22, -1,  -1, 0, 1'b1};
        frames[7] = '{7'h33, -1,  -1, 0, 1'b0};
        frames[8] = '{7'h44, -1,  -1, 0, 1'b0};
        frames[9] = '{7'h55, 139, -1, 0, 1'b0};
        pops[0] = '{7'h01, 1'b0};
        pops[1] = '{7'h02, 1'b1};
        pops[2] = '{7'h03, 1'b1};
        pops[3] = '{7'h04, 1'b1};
        pops[4] = '{7'h22, 1'b0};
        pops[5] = '{7'h33, 1'b1};
        pops[6] = '{7'h44, 1'b1};
        pops[7] = '{7'h55, 1'b1};

        rst        = 1'b1;
        rx         = 1'b1;
        data_ready = 1'b0;
        repeat (3) tick();
        check("reset data_out", data_out, 0);
        check("reset data_valid", data_valid, 0);
        check("reset rts", rts, 1);
        check("reset frame_err", frame_err, 0);
        check("reset overrun", overrun, 0);
        check("reset busy", busy, 0);
        rst = 1'b0;
        repeat (4) tick();

        // Basic frame and latency.
        run_frame(7'h55, 1'b1, 1'b1, 160, -1, va, fe, ov);
        check("basic valid_at", va, 140);
        check("basic data", data_out, 7'h55);
        check("basic frame_err", fe, 0);
        check("basic overrun", ov, 0);
        repeat (20) tick();
        check("basic valid held", data_valid, 1);
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
        check("basic popped", data_valid, 0);

        // Glitch shorter than half a bit.
        rx = 1'b0;
        repeat (5) tick();
        rx      = 1'b1;
        busy_n  = 0;
        flag_n  = 0;
        valid_n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            busy_n  += int'(busy);
            flag_n  += int'(frame_err) + int'(overrun);
            valid_n += int'(data_valid);
        end
        check("glitch busy cycles", busy_n, 5);
        check("glitch busy end", busy, 0);
        check("glitch valid", valid_n, 0);
        check("glitch flags", flag_n, 0);

        // Bad stop bit followed by a held-low line.
        run_frame(7'h2A, 1'b0, 1'b0, 184, -1, va, fe, ov);
        check("break frame_err count", fe, 1);
        check("break overrun", ov, 0);
        check("break valid", data_valid, 0);
        check("break busy held", busy, 1);
        rx = 1'b1;
        repeat (6) tick();
        check("break busy released", busy, 0);
        check("break fifo empty", data_valid, 0);

        // Flow control, overrun, then collision of push with pop on a full FIFO.
        for (int i = 0; i < 10; i++) begin
            run_frame(frames[i].data, 1'b1, 1'b1, 160, frames[i].pop_at, va, fe, ov);
            check($sformatf("frame%0d valid_at", i), va, frames[i].exp_valid_at);
            check($sformatf("frame%0d overrun", i), ov, frames[i].exp_ovr);
            check($sformatf("frame%0d frame_err", i), fe, 0);
            check($sformatf("frame%0d rts", i), rts, frames[i].exp_rts);
            if (i == 4 || i == 9) begin
                for (int p = (i == 4) ? 0 : 4; p < ((i == 4) ? 4 : 8); p++)
                    pop_check(pops[p], p);
                check($sformatf("frame%0d drained", i), data_valid, 0);
            end
        end

        // Reset during bit 3 with two words buffered.
        run_frame(7'h0A, 1'b1, 1'b1, 160, -1, va, fe, ov);
        run_frame(7'h0B, 1'b1, 1'b1, 160, -1, va, fe, ov);
        check("prereset valid", data_valid, 1);
        run_frame(7'h3C, 1'b1, 1'b1, 72, -1, va, fe, ov);
        check("prereset busy", busy, 1);
        rst = 1'b1;
        rx  = 1'b1;
        #1;
        check("midrst data_valid", data_valid, 0);
        check("midrst data_out", data_out, 0);
        check("midrst rts", rts, 1);
        check("midrst busy", busy, 0);
        check("midrst frame_err", frame_err, 0);
        check("midrst overrun", overrun, 0);
        repeat (3) tick();
        rst = 1'b0;
        repeat (4) tick();
        run_frame(7'h7F, 1'b1, 1'b1, 160, -1, va, fe, ov);
        check("postrst valid_at", va, 140);
        check("postrst data", data_out, 7'h7F);
        check("postrst frame_err", fe, 0);
        check("postrst overrun", ov, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver that pairs with the transmit block on the same serial link.
- Oversamples the incoming line on baud_clk, which runs at OVERSAMPLE times the bit rate.
- Deframes start / DATA_BITS / stop, then buffers received words in a small FIFO toward the BNN input logic.
- Drives rts for hardware flow control and flags framing and overrun errors.

Parameters:
- DATA_BITS, 7, data bits per frame, sent LSB first.
- OVERSAMPLE, 16, baud_clk ticks per bit; even, at least 4.
- DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
- rst  input  1  asynchronous active-high reset
- baud_clk  input  1  oversampling clock
- rx  input  1  serial line, idle high, asynchronous to baud_clk
- data_out  output  DATA_BITS  FIFO head word
- data_valid  output  1  FIFO not empty
- data_ready  input  1  consumer pops head when data_valid && data_ready
- rts  output  1  high = sender may start a new frame
- frame_err  output  1  one-cycle pulse on bad stop bit
- overrun  output  1  one-cycle pulse when a good word is dropped because the FIFO is full
- busy  output  1  high while not in IDLE

Behaviour:
- Reset and clocking:
  - Reset is rst, asynchronous, active-high; clock is baud_clk. All flops are reset asynchronously.
  - Reset values: data_out=0, data_valid=0, rts=1, frame_err=0, overrun=0, busy=0; FIFO empty; state IDLE; synchroniser flops = 1.
- Input synchronisation:
  - rx passes through 2 flops to give rx_s; all logic uses rx_s.
- IDLE:
  - On rx_s==0, go to START and clear tick_cnt.
- START:
  - tick_cnt counts baud_clk ticks.
  - At tick_cnt==OVERSAMPLE/2-1 (mid start bit), re-sample rx_s:
    - rx_s==1: false start, return to IDLE with no flags.
    - rx_s==0: go to DATA with tick_cnt=0 and bit_idx=0.
- DATA:
  - At each tick_cnt==OVERSAMPLE-1, sample rx_s into shift[bit_idx] (LSB first), clear tick_cnt and increment bit_idx.
  - After bit DATA_BITS-1, go to STOP.
- STOP:
  - At tick_cnt==OVERSAMPLE-1, sample rx_s.
    - rx_s==1: push shift into the FIFO and go to IDLE.
    - rx_s==0: pulse frame_err for 1 cycle, discard the word, go to WAIT_IDLE.
- WAIT_IDLE:
  - Stay until rx_s==1, then go to IDLE. A break or held-low line produces exactly one frame_err.
- FIFO:
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
  - Push is accepted if count<DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the word is dropped, overrun pulses for 1 cycle, and FIFO contents are unchanged.
  - Simultaneous push and pop leaves count unchanged.
  - data_out shows the head entry combinationally from the FIFO storage. It holds the last value when empty and is don't-care to the consumer.
  - data_valid = count!=0.
- Latency:
  - data_valid rises on the baud_clk edge after the STOP mid-sample edge (FIFO previously empty).
- Flow control:
  - rts is registered and = (count < DEPTH-1), reserving one slot for a frame already in flight.
  - Deasserting rts never aborts a frame in progress.
- Mid-frame reset:
  - Reset returns to IDLE, empties the FIFO and produces no flags.
  - After release, a line still low is treated as a new start edge. If the mid-start sample then sees high, it is a false start; otherwise the frame will likely error into WAIT_IDLE.
- busy = state!=IDLE.

Test Plan:
- Defaults (OVERSAMPLE=16, DATA_BITS=7, DEPTH=4). Send frame 0x55 at exactly 16 ticks/bit -> data_valid=1, data_out=7'h55 one cycle after the stop-bit mid-sample; frame_err=0, overrun=0; data_valid stays high until a data_ready pop.
- Glitch: rx low for 5 ticks, then high -> no state change beyond START; busy returns to 0; no data_valid; no flags.
- Framing error: send 0x2A with stop bit = 0, then hold rx low for 40 ticks -> exactly one frame_err pulse; FIFO empty; busy stays high until rx returns high.
- Flow control and overrun: data_ready=0; send 0x01, 0x02, 0x03 -> rts falls after the 3rd; send 0x04 -> count=4; send 0x05 -> overrun pulse, 0x05 dropped. Pop all -> data_out sequence 01, 02, 03, 04; rts=1 once count<3.
- Push/pop collision: FIFO full, data_ready=1 held on the cycle the 5th frame pushes -> no overrun; count stays 4; order preserved.
- Reset mid-frame: assert rst during bit 3 of a frame with 2 words buffered -> all outputs at reset values immediately, FIFO empty. Release rst with rx idle high, send 0x7F -> received correctly.
